// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: one 128-bit state per handshake, LANES bytes
// substituted per cycle through a shared set of inverse S-box lookups.
module inv_sub_bytes_iter #(
    parameter int LANES = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] in_state_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] out_state_o,
    output logic         busy_o
);
    localparam int BEATS = 16 / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
        $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [127:0]   work_q, work_d;
    logic           accept;
    logic           last_beat;
    logic [6:0]     lane_base;

    assign accept    = in_valid_i & in_ready_o;
    assign last_beat = (cnt_q == CW'(BEATS - 1));
    // Bit offset of the first byte handled this beat; only the LANES bytes
    // at this offset pass through the shared lookups.
    assign lane_base = 7'(cnt_q) * 7'(LANES * 8);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SUB;
            SUB:     if (last_beat) state_d = DONE;
            DONE:    if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        work_d = work_q;
        cnt_d  = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    work_d = in_state_i;
                    cnt_d  = '0;
                end
            end
            SUB: begin
                for (int l = 0; l < LANES; l++) begin
                    work_d[lane_base + 7'(l * 8) +: 8] = INV_SBOX[work_q[lane_base + 7'(l * 8) +: 8]];
                end
                cnt_d = last_beat ? '0 : cnt_q + CW'(1);
            end
            default: ;
        endcase
    end

    // in_ready_o looks at state and reset only, never at in_valid_i.
    always_comb begin
        in_ready_o  = (state_q == IDLE) && !rst_i;
        out_valid_o = (state_q == DONE);
        busy_o      = (state_q != IDLE);
        out_state_o = work_q;
    end

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter at LANES=1, 4 and 16; expectations come from
// constants and a forward S-box built from GF(2^8) arithmetic.
module tb_inv_sub_bytes_iter;
    logic         clk;
    logic         rst       [3];
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_state  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_state [3];
    logic         busy      [3];

    int           n_tests;
    int           n_fail;
    logic [127:0] exp_q[$];
    logic [7:0]   fwd [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    inv_sub_bytes_iter #(.LANES(1)) u_l1 (
        .clk_i(clk), .rst_i(rst[0]), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .in_state_i(in_state[0]), .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
        .out_state_o(out_state[0]), .busy_o(busy[0])
    );
    inv_sub_bytes_iter #(.LANES(4)) u_l4 (
        .clk_i(clk), .rst_i(rst[1]), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .in_state_i(in_state[1]), .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
        .out_state_o(out_state[1]), .busy_o(busy[1])
    );
    inv_sub_bytes_iter #(.LANES(16)) u_l16 (
        .clk_i(clk), .rst_i(rst[2]), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
        .in_state_i(in_state[2]), .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]),
        .out_state_o(out_state[2]), .busy_o(busy[2])
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int beats_of(input int k);
        case (k)
            0:       return 16;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return {b[7:0], b[7:0]} >> (8 - n);
    endfunction

    task automatic build_fwd();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            fwd[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] apply_fwd(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = fwd[s[i*8 +: 8]];
        return r;
    endfunction

    // Drive one block and hold it until accepted; returns at #1 after the accepting edge.
    task automatic drive_block(input int k, input logic [127:0] data, output bit ok);
        int t;
        ok          = 1'b1;
        in_state[k] = data;
        in_valid[k] = 1'b1;
        t = 0;
        while (!in_ready[k] && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready[k]) ok = 1'b0;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_valid(input int k, output int lat);
        lat = 0;
        while (!out_valid[k] && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; in_valid[k] = 1'b0; out_ready[k] = 1'b0; in_state[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (in_ready[k] !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready k=%0d: got %b expected 0", k, in_ready[k]); end
            n_tests++;
            if (out_valid[k] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid k=%0d: got %b expected 0", k, out_valid[k]); end
            n_tests++;
            if (out_state[k] !== 128'h0) begin n_fail++; $display("FAIL reset_out_state k=%0d: got %h expected 0", k, out_state[k]); end
            n_tests++;
            if (busy[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy k=%0d: got %b expected 0", k, busy[k]); end
            rst[k] = 1'b0;
        end
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (in_ready[k] !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready k=%0d: got %b expected 1", k, in_ready[k]); end
        end
    endtask

    task automatic test_basic(input int k);
        bit ok;
        int lat;
        out_ready[k] = 1'b1;
        exp_q.push_back(128'h0f0e0d0c0b0a09080706050403020100);
        drive_block(k, 128'h76abd7fe2b670130c56f6bf27b777c63, ok);
        n_tests++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_accept k=%0d: got %b expected 1", k, ok); end
        n_tests++;
        if (busy[k] !== 1'b1 || out_valid[k] !== 1'b0) begin
            n_fail++; $display("FAIL basic_sub_flags k=%0d: got busy=%b valid=%b expected busy=1 valid=0", k, busy[k], out_valid[k]);
        end
        wait_valid(k, lat);
        n_tests++;
        if (lat !== beats_of(k)) begin n_fail++; $display("FAIL basic_latency k=%0d: got %0d expected %0d", k, lat, beats_of(k)); end
        n_tests++;
        if (out_state[k] !== exp_q[0]) begin n_fail++; $display("FAIL basic_data k=%0d: got %h expected %h", k, out_state[k], exp_q[0]); end
        void'(exp_q.pop_front());
        @(posedge clk); #1;
        n_tests++;
        if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
            n_fail++; $display("FAIL basic_handoff k=%0d: got valid=%b ready=%b busy=%b expected 0 1 0", k, out_valid[k], in_ready[k], busy[k]);
        end
    endtask

    task automatic test_uniform(input int k);
        logic [7:0] b_in, b_out;
        bit ok;
        int lat;
        out_ready[k] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin b_in = 8'h00; b_out = 8'h52; end
                1:       begin b_in = 8'h16; b_out = 8'hff; end
                default: begin b_in = 8'hed; b_out = 8'h53; end
            endcase
            exp_q.push_back({16{b_out}});
            drive_block(k, {16{b_in}}, ok);
            wait_valid(k, lat);
            n_tests++;
            if (out_valid[k] !== 1'b1 || out_state[k] !== exp_q[0]) begin
                n_fail++; $display("FAIL uniform_%02h k=%0d: got valid=%b %h expected %h", b_in, k, out_valid[k], out_state[k], exp_q[0]);
            end
            void'(exp_q.pop_front());
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure(input int k);
        logic [127:0] orig;
        bit ok;
        int lat;
        orig = {$urandom(), $urandom(), $urandom(), $urandom()};
        out_ready[k] = 1'b0;
        exp_q.push_back(orig);
        drive_block(k, apply_fwd(orig), ok);
        wait_valid(k, lat);
        for (int c = 0; c < 10; c++) begin
            n_tests++;
            if (out_valid[k] !== 1'b1 || out_state[k] !== exp_q[0] || in_ready[k] !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold k=%0d cyc=%0d: got valid=%b ready=%b %h expected 1 0 %h",
                                   k, c, out_valid[k], in_ready[k], out_state[k], exp_q[0]);
            end
            in_valid[k] = ($urandom_range(0, 1) == 1);
            in_state[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge clk); #1;
        end
        in_valid[k]  = 1'b0;
        n_tests++;
        if (out_state[k] !== exp_q[0]) begin n_fail++; $display("FAIL stall_final k=%0d: got %h expected %h", k, out_state[k], exp_q[0]); end
        void'(exp_q.pop_front());
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
            n_fail++; $display("FAIL stall_release k=%0d: got valid=%b ready=%b expected 0 1", k, out_valid[k], in_ready[k]);
        end
        repeat (beats_of(k) + 3) begin
            n_tests++;
            if (out_valid[k] !== 1'b0 || busy[k] !== 1'b0) begin
                n_fail++; $display("FAIL stall_no_queue k=%0d: got valid=%b busy=%b expected 0 0", k, out_valid[k], busy[k]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid(input int k);
        bit ok;
        bit seen;
        int lat;
        out_ready[k] = 1'b1;
        drive_block(k, {16{8'h11}}, ok);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[k] = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (out_valid[k] !== 1'b0 || out_state[k] !== 128'h0 || busy[k] !== 1'b0 || in_ready[k] !== 1'b0) begin
            n_fail++; $display("FAIL abort_reset k=%0d: got valid=%b busy=%b ready=%b %h expected 0 0 0 0",
                               k, out_valid[k], busy[k], in_ready[k], out_state[k]);
        end
        rst[k] = 1'b0;
        #1;
        n_tests++;
        if (in_ready[k] !== 1'b1) begin n_fail++; $display("FAIL abort_ready k=%0d: got %b expected 1", k, in_ready[k]); end
        @(posedge clk); #1;
        seen = 1'b0;
        repeat (beats_of(k) + 4) begin
            if (out_valid[k] === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_tests++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_output k=%0d: got valid pulse expected none", k); end
        exp_q.push_back(128'h0);
        drive_block(k, {16{8'h63}}, ok);
        wait_valid(k, lat);
        n_tests++;
        if (out_valid[k] !== 1'b1 || out_state[k] !== exp_q[0]) begin
            n_fail++; $display("FAIL abort_next_block k=%0d: got valid=%b %h expected %h", k, out_valid[k], out_state[k], exp_q[0]);
        end
        void'(exp_q.pop_front());
        @(posedge clk); #1;
    endtask

    task automatic test_round_trip(input int k, input int n);
        int got_n;
        int cycles;
        int budget;
        exp_q.delete();
        budget = n * (beats_of(k) + 16) + 200;
        got_n  = 0;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    logic [127:0] orig;
                    bit ok;
                    orig = {$urandom(), $urandom(), $urandom(), $urandom()};
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    exp_q.push_back(orig);
                    drive_block(k, apply_fwd(orig), ok);
                    if (!ok) begin
                        n_tests++; n_fail++;
                        $display("FAIL rt_accept k=%0d: got no accept expected accept for block %0d", k, i);
                        break;
                    end
                end
            end
            begin
                cycles = 0;
                while (got_n < n && cycles < budget) begin
                    out_ready[k] = ($urandom_range(0, 3) != 0);
                    if (out_valid[k] && out_ready[k]) begin
                        n_tests++;
                        if (exp_q.size() == 0) begin
                            n_fail++; $display("FAIL rt_unexpected k=%0d: got %h expected no output", k, out_state[k]);
                        end else begin
                            if (out_state[k] !== exp_q[0]) begin
                                n_fail++; $display("FAIL rt_data k=%0d blk=%0d: got %h expected %h", k, got_n, out_state[k], exp_q[0]);
                            end
                            void'(exp_q.pop_front());
                        end
                        got_n++;
                    end
                    @(posedge clk); #1;
                    cycles++;
                end
            end
        join
        out_ready[k] = 1'b1;
        n_tests++;
        if (got_n != n) begin n_fail++; $display("FAIL rt_count k=%0d: got %0d expected %0d", k, got_n, n); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        build_fwd();
        test_reset();
        for (int k = 0; k < 3; k++) test_basic(k);
        test_uniform(1);
        test_backpressure(1);
        test_reset_mid(1);
        test_round_trip(1, 1000);
        test_round_trip(0, 300);
        test_round_trip(2, 300);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
